// File: rtl/mfcc_frame_sched.sv
// mfcc_frame_sched: buffers a float sample stream and replays it as overlapping
// FRAME_LEN-sample frames, advancing HOP samples per frame, over valid/ready.
module mfcc_frame_sched #(
    parameter int DW        = 32,
    parameter int FRAME_LEN = 256,
    parameter int HOP       = 128,
    parameter int DEPTH     = 512,
    parameter int AW        = 9,
    parameter int CW        = 16
) (
    input  logic          hclk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          frame_done,
    output logic [CW-1:0] frame_cnt,
    output logic          busy
);
    localparam int BW = $clog2(FRAME_LEN + 1);

    typedef enum logic [1:0] {IDLE, FILL, SEND, ADV} state_t;

    state_t        state;
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp, fb, rp;
    logic [AW:0]   occ;
    logic [BW-1:0] beat;
    logic          wr;

    assign s_ready    = (state != IDLE) && (occ < (AW+1)'(DEPTH));
    assign wr         = s_valid && s_ready;
    assign busy       = state != IDLE;
    assign frame_done = state == ADV;

    // Writes only land outside [fb, fb+occ), so the frame being read is never touched.
    always_ff @(posedge hclk) begin
        if (wr) mem[wp] <= s_data;
    end

    always_ff @(posedge hclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wp        <= '0;
            fb        <= '0;
            rp        <= '0;
            occ       <= '0;
            beat      <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            occ <= occ + (AW+1)'(wr);
            case (state)
                IDLE: begin
                    if (enable) begin
                        state     <= FILL;
                        frame_cnt <= '0;
                    end
                end
                FILL: begin
                    if (occ >= (AW+1)'(FRAME_LEN)) begin
                        state <= SEND;
                        rp    <= fb;
                        beat  <= '0;
                    end else if (!enable) begin
                        state <= IDLE;
                        wp    <= '0;
                        fb    <= '0;
                        occ   <= '0;
                    end
                end
                SEND: begin
                    if (m_valid && m_ready && m_last) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        state   <= ADV;
                    end else if ((!m_valid || m_ready) && beat != BW'(FRAME_LEN)) begin
                        m_data  <= mem[rp];
                        m_valid <= 1'b1;
                        m_last  <= beat == BW'(FRAME_LEN - 1);
                        rp      <= rp + AW'(1);
                        beat    <= beat + BW'(1);
                    end
                end
                ADV: begin
                    fb        <= fb + AW'(HOP);
                    occ       <= occ + (AW+1)'(wr) - (AW+1)'(HOP);
                    frame_cnt <= frame_cnt + CW'(1);
                    state     <= enable ? FILL : IDLE;
                    if (!enable) begin
                        wp  <= '0;
                        fb  <= '0;
                        occ <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mfcc_frame_sched.sv
// tb_mfcc_frame_sched: directed, table-driven bench for the frame scheduler;
// a counting source feeds samples and every delivered frame is compared to its expected span.
module tb_mfcc_frame_sched;
    localparam int DW        = 32;
    localparam int FRAME_LEN = 256;
    localparam int HOP       = 128;
    localparam int DEPTH     = 512;
    localparam int AW        = 9;
    localparam int CW        = 16;

    logic          hclk, rst_n, enable;
    logic [DW-1:0] s_data, m_data;
    logic          s_valid, s_ready, m_valid, m_ready, m_last, frame_done, busy;
    logic [CW-1:0] frame_cnt;

    mfcc_frame_sched #(
        .DW(DW), .FRAME_LEN(FRAME_LEN), .HOP(HOP), .DEPTH(DEPTH), .AW(AW), .CW(CW)
    ) dut (
        .hclk(hclk), .rst_n(rst_n), .enable(enable),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        int limit;
        int first;
        int cnt;
    } vec_t;

    vec_t        tbl[4];
    int          checks, failures, hold_err;
    int          next_val, push_limit, rdy_pct;
    logic [DW:0] beats[$];
    logic [DW:0] held;
    logic        hold_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One cycle: inputs change and handshakes are predicted at the negedge.
    task automatic cycle();
        @(negedge hclk);
        if (hold_pend && (m_valid !== 1'b1 || {m_last, m_data} !== held)) hold_err++;
        s_valid = next_val < push_limit;
        s_data  = 32'(next_val);
        m_ready = int'($urandom_range(99, 0)) < rdy_pct;
        if (s_valid && s_ready) next_val++;
        if (m_valid && m_ready) beats.push_back({m_last, m_data});
        hold_pend = m_valid && !m_ready;
        held      = {m_last, m_data};
    endtask

    task automatic expect_frame(input string name, input int first, input int cnt, input int drop_at);
        int bad_d = 0;
        int bad_l = 0;
        int n = 0;
        beats.delete();
        hold_err = 0;
        while (beats.size() < FRAME_LEN && n < 8000) begin
            cycle();
            n++;
            if (beats.size() == drop_at) enable = 1'b0;
        end
        chk({name, " beats"}, 64'(beats.size()), 64'(FRAME_LEN));
        foreach (beats[i]) begin
            if (beats[i][DW-1:0] != 32'(first + i)) bad_d++;
            if (beats[i][DW] != (i == FRAME_LEN - 1)) bad_l++;
        end
        chk({name, " data_errs"}, 64'(bad_d), 0);
        chk({name, " last_errs"}, 64'(bad_l), 0);
        chk({name, " hold_errs"}, 64'(hold_err), 0);
        cycle();
        chk({name, " frame_done"}, 64'(frame_done), 1);
        cycle();
        chk({name, " frame_done_off"}, 64'(frame_done), 0);
        chk({name, " frame_cnt"}, 64'(frame_cnt), 64'(cnt));
    endtask

    task automatic restart(input int limit, input int pct);
        enable = 1'b0;
        push_limit = 0;
        repeat (3) cycle();
        chk("idle busy", 64'(busy), 0);
        chk("idle s_ready", 64'(s_ready), 0);
        next_val   = 0;
        push_limit = limit;
        rdy_pct    = pct;
        enable     = 1'b1;
    endtask

    initial begin
        int n;
        tbl[0] = '{256, 0, 1};
        tbl[1] = '{384, 128, 2};
        tbl[2] = '{512, 256, 3};
        tbl[3] = '{640, 384, 4};
        checks = 0; failures = 0; hold_err = 0;
        rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        next_val = 0; push_limit = 0; rdy_pct = 100; hold_pend = 1'b0; held = '0;
        repeat (2) @(negedge hclk);
        chk("rst m_valid", 64'(m_valid), 0);
        chk("rst m_last", 64'(m_last), 0);
        chk("rst m_data", 64'(m_data), 0);
        chk("rst busy", 64'(busy), 0);
        chk("rst s_ready", 64'(s_ready), 0);
        chk("rst frame_done", 64'(frame_done), 0);
        chk("rst frame_cnt", 64'(frame_cnt), 0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Overlapping frames, the last one spanning the buffer wrap.
        for (int i = 0; i < 4; i++) begin
            push_limit = tbl[i].limit;
            expect_frame($sformatf("ovl%0d", i), tbl[i].first, tbl[i].cnt, -1);
        end

        restart(256, 50);
        expect_frame("bp", 0, 1, -1);

        restart(600, 0);
        hold_err = 0;
        repeat (700) cycle();
        chk("full accepted", 64'(next_val), 512);
        chk("full s_ready", 64'(s_ready), 0);
        chk("full hold_errs", 64'(hold_err), 0);
        rdy_pct = 100;
        expect_frame("full0", 0, 1, -1);
        expect_frame("full1", 128, 2, -1);
        expect_frame("full2", 256, 3, -1);
        repeat (20) cycle();
        chk("full all accepted", 64'(next_val), 600);

        restart(100000, 100);
        expect_frame("stop0", 0, 1, -1);
        expect_frame("stop1", 128, 2, 100);
        chk("stop busy", 64'(busy), 0);
        chk("stop s_ready", 64'(s_ready), 0);
        next_val   = 2000;
        push_limit = 2256;
        enable     = 1'b1;
        expect_frame("fresh", 2000, 1, -1);

        push_limit = 3000;
        beats.delete();
        n = 0;
        while (beats.size() < 50 && n < 2000) begin
            cycle();
            n++;
        end
        chk("rst reached beat50", 64'(beats.size()), 50);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst m_valid", 64'(m_valid), 0);
        chk("midrst m_last", 64'(m_last), 0);
        chk("midrst busy", 64'(busy), 0);
        chk("midrst frame_cnt", 64'(frame_cnt), 0);
        @(negedge hclk);
        rst_n      = 1'b1;
        hold_pend  = 1'b0;
        next_val   = 0;
        push_limit = 256;
        expect_frame("post_rst", 0, 1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mfcc_frame_sched.md
Name: mfcc_frame_sched

Overview:
- Frame scheduler in front of the Hann-window stage of the MFCC front end.
- Buffers the incoming 32-bit float audio sample stream in a circular buffer.
- Cuts the stream into overlapping frames of FRAME_LEN samples, advancing HOP samples per frame.
- Streams each frame into the window block over a valid/ready handshake, with last on the final sample.

Parameters:
- DW, 32, sample width in bits (IEEE-754 single)
- FRAME_LEN, 256, samples per frame
- HOP, 128, frame advance in samples; legal range 1..FRAME_LEN
- DEPTH, 512, buffer entries; equals 2*FRAME_LEN, power of two
- AW, 9, log2(DEPTH)
- CW, 16, frame counter width

Ports:
- hclk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request from register block
- s_data  in  DW  input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample accepted when s_valid&&s_ready
- m_data  out  DW  sample to window stage (drives its data_in)
- m_valid  out  1  m_data valid (drives valid_in)
- m_ready  in  1  window stage ready (from ready_out)
- m_last  out  1  high with the last sample of a frame
- frame_done  out  1  one-cycle pulse after a frame's last beat
- frame_cnt  out  CW  frames issued since enable; wraps at 2^CW
- busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; wp, fb, rp, occ, beat=0; s_ready, m_valid, m_last, frame_done, busy=0; m_data=0; frame_cnt=0.
- Storage: DEPTH x DW array with combinational read.
  - wp: write pointer.
  - fb: frame base.
  - occ: samples held from fb onward; range 0..DEPTH.
- Write side:
  - s_ready = (state!=IDLE) && (occ<DEPTH).
  - On accept: mem[wp]<=s_data, wp<=wp+1 (mod DEPTH), occ+1.
- FSM states IDLE, FILL, SEND, ADV:
  - IDLE: enable=1 -> FILL, with frame_cnt cleared.
  - FILL: occ>=FRAME_LEN -> SEND, with rp<=fb, beat<=0. enable=0 -> IDLE, flushing pointers.
  - SEND: registered output stage. Load when !m_valid || m_ready:
    - m_data<=mem[rp], m_valid<=1, m_last<=(beat==FRAME_LEN-1), rp+1, beat+1.
    - After loading beat FRAME_LEN-1, no further loads.
    - On the handshake of the m_last beat: m_valid<=0, m_last<=0, go to ADV.
    - m_data/m_valid/m_last hold stable while m_valid && !m_ready.
  - ADV (one cycle): fb<=fb+HOP, occ-=HOP, frame_cnt+1, frame_done=1 this cycle. Then FILL if enable, else IDLE with flush.
- Latency:
  - FILL->SEND transition at edge t; first m_valid high after edge t+1.
  - With m_ready=1 continuously: one beat per cycle, FRAME_LEN+1 cycles from SEND entry to ADV.
- Simultaneous write and ADV: occ <= occ+1-HOP.
- Writes never corrupt the frame being read: only entries outside [fb, fb+occ) are written.
- Wrap-around: all pointer arithmetic modulo DEPTH. Frames spanning index DEPTH-1 -> 0 must be seamless.
- enable dropped during SEND: the current frame completes, then ADV, then IDLE with flush.
- busy=1 in FILL/SEND/ADV.
- Flush on entering IDLE: wp=fb=occ=0. Stored samples are discarded.
- Input is stalled only by occ==DEPTH. Samples are never dropped.
- Asynchronous reset mid-frame aborts immediately. No partial m_last is issued.

Test Plan:
- Basic frame: enable=1, push 256 samples with values 0..255, m_ready=1 -> 256 beats of data 0..255; m_last only on 255; frame_done one cycle after; frame_cnt=1.
- Overlap: continue pushing 256..383 -> second frame carries 128..383, frame_cnt=2. Third frame, after samples up to 511, carries 256..511. Fourth frame wraps the buffer and carries 384..639.
- Backpressure: m_ready random 50% -> output sequence identical to basic case; m_data stable whenever m_valid && !m_ready.
- Full: m_ready=0, push 600 samples -> s_ready=0 after 512 accepted. Release m_ready -> frames 0..255, then 128..383. Input then resumes; no sample lost.
- Stop: deassert enable at beat 100 of frame 1 -> beats 100..255 still delivered; frame_done pulses; then busy=0 and s_ready=0. Re-enable -> the next frame starts from fresh samples, frame_cnt=1.
- Reset mid-SEND: pull rst_n low at beat 50 -> m_valid, m_last, busy, frame_cnt go to 0 immediately. After release, the basic frame test passes again.
